// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and state encoding for the product accumulator
package arith_pkg;

  localparam int PROD_W_DEF  = 8;
  localparam int ACC_W_DEF   = 16;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  // Sign-extend a PROD_W-bit value into an ACC_W-bit field.
  function automatic logic [63:0] sext64(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed saturating adder
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         clipped
);

  logic [W:0] wide;

  // Add with one guard bit; a disagreement between the top two bits means overflow.
  always_comb begin
    wide    = {a[W-1], a} + {b[W-1], b};
    clipped = (wide[W] != wide[W-1]);
    if (!clipped) begin
      sum = wide[W-1:0];
    end else if (wide[W]) begin
      sum = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - packetised saturating accumulator of signed products
module product_accumulator
  import arith_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_clip;
  logic             accept;
  logic             terminate;

  assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign accept   = in_valid && in_ready_q;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a       (acc_q),
    .b       (prod_ext),
    .sum     (add_sum),
    .clipped (add_clip)
  );

  // Next-state: load on first beat, saturate-accumulate afterwards, hold until drained.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sat_d     = sat_q;
    terminate = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d     = prod_ext;
          count_d   = CNT_W'(1);
          sat_d     = 1'b0;
          terminate = in_last || (CNT_W'(1) == CNT_W'(MAX_LEN));
          state_d   = terminate ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d     = add_sum;
          count_d   = count_q + CNT_W'(1);
          sat_d     = sat_q | add_clip;
          terminate = in_last || (count_d == CNT_W'(MAX_LEN));
          state_d   = terminate ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d != ST_HOLD);
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and registered handshake outputs; reset discards any partial or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed table-driven bench for product_accumulator
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_in_valid = 1'b0, a_in_ready, a_in_last = 1'b0;
  logic [7:0] a_in_prod = '0;
  logic       a_out_valid, a_out_ready = 1'b0, a_out_sat;
  logic [15:0] a_out_sum;
  logic [4:0]  a_out_count;

  logic       b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0;
  logic [7:0] b_in_prod = '0;
  logic       b_out_valid, b_out_ready = 1'b0, b_out_sat;
  logic [9:0] b_out_sum;
  logic [4:0] b_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .MAX_LEN(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_count(a_out_count), .out_sat(a_out_sat)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(10), .MAX_LEN(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_sat(b_out_sat)
  );

  typedef struct {
    logic v;
    int   p;
    logic l;
    logic o;
    logic e_ov;
    logic e_ir;
    logic chk_data;
    int   e_sum;
    int   e_cnt;
    logic e_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input int p, input logic l, input logic o,
                              input logic e_ov, input logic e_ir, input logic chk_data,
                              input int e_sum, input int e_cnt, input logic e_sat);
    vec_t r;
    r.v = v; r.p = p; r.l = l; r.o = o;
    r.e_ov = e_ov; r.e_ir = e_ir; r.chk_data = chk_data;
    r.e_sum = e_sum; r.e_cnt = e_cnt; r.e_sat = e_sat;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input int p, input logic l, input logic o);
    a_in_valid  = v;
    a_in_prod   = 8'(p);
    a_in_last   = l;
    a_out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input int p, input logic l, input logic o);
    b_in_valid  = v;
    b_in_prod   = 8'(p);
    b_in_last   = l;
    b_out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic ov, input logic ir,
                       input int sum, input int cnt, input logic sat);
    chk({name, ".out_valid"}, int'(a_out_valid), int'(ov));
    chk({name, ".in_ready"},  int'(a_in_ready),  int'(ir));
    chk({name, ".out_sum"},   int'($signed(a_out_sum)), sum);
    chk({name, ".out_count"}, int'(a_out_count), cnt);
    chk({name, ".out_sat"},   int'(a_out_sat),   int'(sat));
  endtask

  task automatic chk_b(input string name, input logic ov,
                       input int sum, input int cnt, input logic sat);
    chk({name, ".out_valid"}, int'(b_out_valid), int'(ov));
    chk({name, ".out_sum"},   int'($signed(b_out_sum)), sum);
    chk({name, ".out_count"}, int'(b_out_count), cnt);
    chk({name, ".out_sat"},   int'(b_out_sat),   int'(sat));
  endtask

  initial begin
    vecs.push_back(mk(1, 5,    0, 0, 0, 1, 1, 5,    1, 0));
    vecs.push_back(mk(1, -3,   0, 0, 0, 1, 1, 2,    2, 0));
    vecs.push_back(mk(1, 7,    1, 0, 1, 0, 1, 9,    3, 0));
    vecs.push_back(mk(1, 99,   1, 1, 0, 1, 0, 0,    0, 0));
    vecs.push_back(mk(1, -128, 1, 0, 1, 0, 1, -128, 1, 0));
    vecs.push_back(mk(0, 0,    0, 1, 0, 1, 0, 0,    0, 0));
    vecs.push_back(mk(1, 127,  0, 0, 0, 1, 1, 127,  1, 0));
    vecs.push_back(mk(1, -100, 1, 0, 1, 0, 1, 27,   2, 0));
    vecs.push_back(mk(0, 0,    0, 1, 0, 1, 0, 0,    0, 0));
    vecs.push_back(mk(0, 0,    0, 0, 0, 1, 0, 0,    0, 0));

    // reset state
    rst = 1'b1;
    step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    chk_a("reset_a", 0, 1, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);
    rst = 1'b0;

    // table vectors
    foreach (vecs[i]) begin
      step_a(vecs[i].v, vecs[i].p, vecs[i].l, vecs[i].o);
      chk($sformatf("vec%0d.out_valid", i), int'(a_out_valid), int'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i),  int'(a_in_ready),  int'(vecs[i].e_ir));
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d.out_sum", i),   int'($signed(a_out_sum)), vecs[i].e_sum);
        chk($sformatf("vec%0d.out_count", i), int'(a_out_count), vecs[i].e_cnt);
        chk($sformatf("vec%0d.out_sat", i),   int'(a_out_sat),   int'(vecs[i].e_sat));
      end
    end

    // forced termination at MAX_LEN without in_last
    for (int i = 0; i < 16; i++) begin
      step_a(1, 1, 0, 0);
      if (i == 14) chk_a("maxlen_15", 0, 1, 15, 15, 0);
    end
    chk_a("maxlen_16", 1, 0, 16, 16, 0);
    step_a(0, 0, 0, 1);
    chk("maxlen_drain.out_valid", int'(a_out_valid), 0);

    // backpressure in HOLD: outputs stable, offered beats ignored
    step_a(1, 40, 1, 0);
    chk_a("hold_enter", 1, 0, 40, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step_a(1, 50, 1, 0);
      chk_a($sformatf("hold_wait%0d", k), 1, 0, 40, 1, 0);
    end
    step_a(1, 50, 1, 1);
    chk("hold_release.out_valid", int'(a_out_valid), 0);
    chk("hold_release.in_ready",  int'(a_in_ready),  1);
    step_a(1, 2, 1, 0);
    chk_a("hold_next_pkt", 1, 0, 2, 1, 0);
    step_a(0, 0, 0, 1);

    // saturation on the narrow accumulator, then sat clears on the next packet
    for (int i = 0; i < 5; i++) begin
      step_b(1, 127, (i == 4), 0);
      if (i == 3) chk_b("sat_b_beat4", 0, 508, 4, 0);
    end
    chk_b("sat_b_done", 1, 511, 5, 1);
    step_b(1, -4, 1, 1);
    chk("sat_b_release.out_valid", int'(b_out_valid), 0);
    step_b(1, -4, 1, 0);
    chk_b("sat_b_next", 1, -4, 1, 0);
    step_b(0, 0, 0, 1);

    // reset mid-packet discards the partial result
    step_a(1, 10, 0, 0);
    step_a(1, 20, 0, 0);
    chk_a("mid_pkt", 0, 1, 30, 2, 0);
    rst = 1'b1;
    step_a(0, 0, 0, 0);
    rst = 1'b0;
    chk_a("mid_rst", 0, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step_a(0, 0, 0, 0);
      chk($sformatf("post_rst%0d.out_valid", k), int'(a_out_valid), 0);
    end
    step_a(1, 1, 1, 0);
    chk_a("post_rst_pkt", 1, 0, 1, 1, 0);
    step_a(0, 0, 0, 1);
    chk("post_rst_drain.out_valid", int'(a_out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
